// File: rtl/vga_text_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_text_pkg
// Description : Shared definitions for the text-mode screen path: grid size
//               defaults, control codes and the writer state type.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_text_pkg;

    // Default character grid and screen RAM address width
    localparam int TEXT_COLS   = 80;
    localparam int TEXT_ROWS   = 30;
    localparam int TEXT_ADDR_W = 12;

    // Cursor register widths (fixed by the port list)
    localparam int COL_W = 7;
    localparam int ROW_W = 5;

    // Control codes interpreted by the writer
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_BS = 8'h08;
    localparam logic [7:0] ASCII_FF = 8'h0C;
    localparam logic [7:0] ASCII_SP = 8'h20;

    // Writer state: clearing the screen or accepting characters
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

    // Bytes that are drawn on screen rather than interpreted or dropped
    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage
`default_nettype wire

// File: rtl/text_cursor.sv
`default_nettype none
// ============================================================================
// Module      : text_cursor
// Description : Column/row cursor with home, advance, newline, carriage
//               return and decrement operations; rows wrap without scrolling.
//               Presents the linear screen address row*COLS + col.
// Revision    : 1.0 - initial release
// ============================================================================
module text_cursor
    import vga_text_pkg::*;
#(
    parameter int COLS   = TEXT_COLS,
    parameter int ROWS   = TEXT_ROWS,
    parameter int ADDR_W = TEXT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              home_i,
    input  logic              advance_i,
    input  logic              newline_i,
    input  logic              cr_i,
    input  logic              decrement_i,
    output logic [COL_W-1:0]  col_o,
    output logic [ROW_W-1:0]  row_o,
    output logic [ADDR_W-1:0] addr_o
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [ROW_W-1:0] w_row_inc;

    // Next row with wrap from the bottom row back to the top
    assign w_row_inc = (row_q == ROW_LAST) ? '0 : row_q + ROW_ONE;

    // Cursor next state; at most one operation is requested per cycle
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (home_i) begin
            col_d = '0;
            row_d = '0;
        end else if (advance_i) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = w_row_inc;
            end else begin
                col_d = col_q + COL_ONE;
            end
        end else if (newline_i) begin
            col_d = '0;
            row_d = w_row_inc;
        end else if (cr_i) begin
            col_d = '0;
        end else if (decrement_i && (col_q != '0)) begin
            col_d = col_q - COL_ONE;
        end
    end

    // Cursor registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o = col_q;
    assign row_o = row_q;

    // Linear address; the 80-column case uses shift-add instead of a multiplier
    if (COLS == 80) begin : g_addr_shift
        logic [ADDR_W-1:0] w_row_ext;
        logic [ADDR_W-1:0] w_col_ext;
        assign w_row_ext = {{(ADDR_W-ROW_W){1'b0}}, row_q};
        assign w_col_ext = {{(ADDR_W-COL_W){1'b0}}, col_q};
        assign addr_o    = (w_row_ext << 6) + (w_row_ext << 4) + w_col_ext;
    end else begin : g_addr_mul
        assign addr_o = ADDR_W'(int'(row_q) * COLS + int'(col_q));
    end

endmodule
`default_nettype wire

// File: rtl/text_writer.sv
`default_nettype none
// ============================================================================
// Module      : text_writer
// Description : Character-stream writer for the text-mode screen RAM. Clears
//               the screen after reset or form feed, then accepts bytes over
//               valid/ready and issues single-byte RAM writes.
// Revision    : 1.0 - initial release
// ============================================================================
module text_writer
    import vga_text_pkg::*;
#(
    parameter int         COLS   = TEXT_COLS,
    parameter int         ROWS   = TEXT_ROWS,
    parameter int         ADDR_W = TEXT_ADDR_W,
    parameter logic [7:0] BLANK  = ASCII_SP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic [COL_W-1:0]  cursor_col,
    output logic [ROW_W-1:0]  cursor_row,
    output logic              busy
);

    // One spare bit so the counter can hold COLS*ROWS as its "done" value
    localparam int                CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  CLR_DONE = CNT_W'(COLS * ROWS);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_e            state_q;
    logic [CNT_W-1:0]  clr_cnt_q;
    logic              in_ready_q;
    logic              busy_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;

    logic              w_accept;
    logic              w_print;
    logic              w_lf;
    logic              w_cr;
    logic              w_bs;
    logic              w_ff;
    logic              w_clr_done;
    logic [COL_W-1:0]  w_col;
    logic [ROW_W-1:0]  w_row;
    logic [ADDR_W-1:0] w_cur_addr;

    // Byte decode; in_ready_q is only high in IDLE so acceptance implies IDLE
    assign w_accept   = in_valid && in_ready_q;
    assign w_print    = w_accept && is_printable(in_data);
    assign w_lf       = w_accept && (in_data == ASCII_LF);
    assign w_cr       = w_accept && (in_data == ASCII_CR);
    assign w_bs       = w_accept && (in_data == ASCII_BS) && (w_col != '0);
    assign w_ff       = w_accept && (in_data == ASCII_FF);
    assign w_clr_done = (state_q == CLEAR) && (clr_cnt_q == CLR_DONE);

    text_cursor #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_cursor (
        .clk         (clk),
        .reset       (reset),
        .home_i      (w_clr_done),
        .advance_i   (w_print),
        .newline_i   (w_lf),
        .cr_i        (w_cr),
        .decrement_i (w_bs),
        .col_o       (w_col),
        .row_o       (w_row),
        .addr_o      (w_cur_addr)
    );

    // Writer FSM: clear sweep, character writes and registered handshake/RAM outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= CLEAR;
            clr_cnt_q  <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                CLEAR: begin
                    if (clr_cnt_q == CLR_DONE) begin
                        // Last blank already presented; open the input side
                        state_q    <= IDLE;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        we_q      <= 1'b1;
                        addr_q    <= clr_cnt_q[ADDR_W-1:0];
                        data_q    <= BLANK;
                        clr_cnt_q <= clr_cnt_q + CNT_ONE;
                    end
                end
                IDLE: begin
                    if (w_print) begin
                        we_q   <= 1'b1;
                        addr_q <= w_cur_addr;
                        data_q <= in_data;
                    end else if (w_bs) begin
                        we_q   <= 1'b1;
                        addr_q <= w_cur_addr - ADDR_ONE;
                        data_q <= BLANK;
                    end else if (w_ff) begin
                        // Address 0 goes out immediately, so the sweep resumes at 1
                        state_q    <= CLEAR;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        we_q       <= 1'b1;
                        addr_q     <= '0;
                        data_q     <= BLANK;
                        clr_cnt_q  <= CNT_ONE;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign ram_we     = we_q;
    assign ram_addr   = addr_q;
    assign ram_data   = data_q;
    assign cursor_col = w_col;
    assign cursor_row = w_row;

endmodule
`default_nettype wire

// File: tb/tb_text_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_text_writer
// Description : Self-checking bench for text_writer: behavioural screen/cursor
//               model compared every cycle, directed scenarios and random bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_text_writer;

    localparam int NCOLS = 80;
    localparam int NROWS = 30;
    localparam int NCELL = NCOLS * NROWS;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [7:0]  ram_data;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    int checks = 0;
    int errors = 0;

    text_writer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Global time limit so the run always terminates
    initial begin
        #(70000 * 10);
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Behavioural model: a screen of cells plus a cursor. A clear is a
    // number of blank writes still owed; a byte is interpreted by its
    // character meaning. Expected outputs are what the writer must show
    // during the cycle following each clock edge.
    // ------------------------------------------------------------------
    bit         started = 0;
    int         clear_left;     // blank writes still owed (-1: not clearing)
    int         clear_addr;     // next blank address
    bit         m_ready, m_busy, m_we;
    int         m_addr, m_data, m_col, m_row;
    logic [7:0] m_screen [NCELL];
    logic [7:0] d_screen [NCELL];

    function automatic void model_reset();
        clear_left = NCELL; clear_addr = 0;
        m_ready = 0; m_busy = 1; m_we = 0;
        m_addr = 0; m_data = 0; m_col = 0; m_row = 0;
    endfunction

    function automatic void model_write(int a, int d);
        m_we = 1; m_addr = a; m_data = d;
        m_screen[a] = d[7:0];
    endfunction

    always @(posedge clk or negedge reset) begin
        started = 1;
        if (!reset) begin
            model_reset();
        end else begin
            m_we = 0;
            if (clear_left > 0) begin
                model_write(clear_addr, 8'h20);
                clear_addr++;
                clear_left--;
            end else if (clear_left == 0) begin
                clear_left = -1;
                m_ready = 1; m_busy = 0; m_col = 0; m_row = 0;
            end else if (in_valid) begin
                int b;
                b = int'(in_data);
                if (b >= 32 && b <= 126) begin
                    model_write(m_row * NCOLS + m_col, b);
                    m_col++;
                    if (m_col == NCOLS) begin m_col = 0; m_row = (m_row + 1) % NROWS; end
                end else if (b == 10) begin
                    m_col = 0; m_row = (m_row + 1) % NROWS;
                end else if (b == 13) begin
                    m_col = 0;
                end else if (b == 8) begin
                    if (m_col > 0) begin m_col--; model_write(m_row * NCOLS + m_col, 8'h20); end
                end else if (b == 12) begin
                    m_ready = 0; m_busy = 1;
                    model_write(0, 8'h20);
                    clear_addr = 1; clear_left = NCELL - 1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Compare process: every cycle, away from the active edge
    // ------------------------------------------------------------------
    typedef struct { int cyc; int addr; int data; } wr_t;
    wr_t wlog[$];
    int  cyc = 0;
    int  we_count = 0;

    always @(negedge clk) begin
        if (started) begin
            cyc++;
            checks++;
            if (ram_we !== m_we || int'(ram_addr) != m_addr || int'(ram_data) != m_data ||
                in_ready !== m_ready || busy !== m_busy ||
                int'(cursor_col) != m_col || int'(cursor_row) != m_row) begin
                errors++;
                $display("FAIL cycle %0d outputs: we=%0d addr=%0d data=%02h rdy=%0d busy=%0d col=%0d row=%0d required we=%0d addr=%0d data=%02h rdy=%0d busy=%0d col=%0d row=%0d",
                         cyc, ram_we, ram_addr, ram_data, in_ready, busy, cursor_col, cursor_row,
                         m_we, m_addr, m_data, m_ready, m_busy, m_col, m_row);
            end
            if (ram_we === 1'b1) begin
                we_count++;
                wlog.push_back('{cyc, int'(ram_addr), int'(ram_data)});
                if (int'(ram_addr) < NCELL) d_screen[ram_addr] = ram_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk); #2;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic wait_ready(input int budget);
        bit ok;
        ok = 0;
        in_valid = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (in_ready === 1'b1) begin ok = 1; break; end
            @(posedge clk); #2;
        end
        chk("wait_ready_timeout", int'(ok), 1);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int ff_budget;
        int diff;
        logic [7:0] b;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 1);
        chk("reset_ready", int'(in_ready), 0);
        chk("reset_we", int'(ram_we), 0);
        @(posedge clk); #2;
        reset = 1'b1;
        we_count = 0;
        wlog.delete();

        // Initial clear: 2400 blanks, ascending, then home and ready
        wait_ready(3000);
        chk("init_clear_count", we_count, 2400);
        chk("init_first_addr", wlog[0].addr, 0);
        chk("init_last_addr", wlog[wlog.size()-1].addr, 2399);
        chk("init_last_data", wlog[wlog.size()-1].data, 8'h20);
        chk("init_busy", int'(busy), 0);
        chk("init_col", int'(cursor_col), 0);

        // "AB" back to back
        wlog.delete();
        put("A"); put("B"); idle(2);
        chk("ab_nwrites", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("ab_w0_addr", wlog[0].addr, 0);
            chk("ab_w0_data", wlog[0].data, 8'h41);
            chk("ab_w1_addr", wlog[1].addr, 1);
            chk("ab_w1_data", wlog[1].data, 8'h42);
            chk("ab_consecutive", wlog[1].cyc - wlog[0].cyc, 1);
        end
        chk("ab_col", int'(cursor_col), 2);

        // Full last row wraps to home
        put(8'h0D);
        for (int i = 0; i < 29; i++) put(8'h0A);
        wlog.delete();
        for (int i = 0; i < 80; i++) put(8'h61 + 8'(i % 26));
        idle(2);
        chk("wrap_nwrites", wlog.size(), 80);
        chk("wrap_last_addr", wlog[wlog.size()-1].addr, 2399);
        chk("wrap_col", int'(cursor_col), 0);
        chk("wrap_row", int'(cursor_row), 0);

        // X, BS, BS at column 0
        wlog.delete();
        put("X"); put(8'h08); put(8'h08); idle(2);
        chk("bs_nwrites", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("bs_w0", wlog[0].addr * 256 + wlog[0].data, 0 * 256 + 8'h58);
            chk("bs_w1", wlog[1].addr * 256 + wlog[1].data, 0 * 256 + 8'h20);
        end
        chk("bs_col", int'(cursor_col), 0);

        // Cursor to (5,3), then LF, CR, and an ignored code
        for (int i = 0; i < 3; i++) put(8'h0A);
        put("h"); put("e"); put("l"); put("l"); put("o");
        idle(1);
        chk("pos_col", int'(cursor_col), 5);
        chk("pos_row", int'(cursor_row), 3);
        wlog.delete();
        put(8'h0A); put(8'h0D); idle(1);
        chk("lfcr_col", int'(cursor_col), 0);
        chk("lfcr_row", int'(cursor_row), 4);
        put(8'h01); idle(1);
        chk("ctl_nwrites", wlog.size(), 0);
        chk("ctl_row", int'(cursor_row), 4);
        chk("ctl_ready", int'(in_ready), 1);

        // Random bytes, including the occasional form feed
        ff_budget = 2;
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 63));
            if (r < 36)       b = 8'($urandom_range(32, 126));
            else if (r < 42)  b = 8'h0A;
            else if (r < 46)  b = 8'h0D;
            else if (r < 54)  b = 8'h08;
            else if (r < 62)  begin b = 8'($urandom_range(0, 255)); if (b == 8'h0C) b = 8'h7F; end
            else if (ff_budget > 0 && i > 150) begin b = 8'h0C; ff_budget--; end
            else              b = 8'h7F;
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = b;
            @(posedge clk); #2;
        end
        wait_ready(3000);
        idle(1);
        diff = 0;
        for (int a = 0; a < NCELL; a++)
            if (d_screen[a] !== m_screen[a]) diff++;
        chk("screen_cells_differing", diff, 0);

        // Form feed mid-stream, then reset halfway through the clear
        put("Q"); put(8'h0C); put("Z");
        idle(1200);
        reset = 1'b0;
        #1;
        chk("midrst_we", int'(ram_we), 0);
        chk("midrst_addr", int'(ram_addr), 0);
        chk("midrst_data", int'(ram_data), 0);
        chk("midrst_ready", int'(in_ready), 0);
        chk("midrst_busy", int'(busy), 1);
        chk("midrst_cursor", int'(cursor_col) + int'(cursor_row), 0);
        @(posedge clk); #2;
        idle(2);
        we_count = 0;
        wlog.delete();
        reset = 1'b1;
        wait_ready(3000);
        chk("reclear_count", we_count, 2400);
        chk("reclear_first_addr", wlog[0].addr, 0);
        chk("reclear_last_addr", wlog[wlog.size()-1].addr, 2399);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/text_writer.md
# text_writer

Character-stream writer for the text-mode screen RAM; it is the producer side of the memory the VGA text path reads. It accepts ASCII bytes over a valid/ready handshake, maintains a cursor on the 80x30 character grid, and issues single-byte writes to screen RAM. It also interprets a small set of control codes. At reset it clears the whole screen before accepting input.

## Interface
- COLS, 80, characters per row
- ROWS, 30, rows per screen
- ADDR_W, 12, screen RAM address width (COLS*ROWS must be at most 2**ADDR_W)
- BLANK, 8'h20, fill byte used by clear and backspace
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  in_data is presented
- in_data  input  8  ASCII byte
- in_ready  output  1  writer can accept a byte this cycle
- ram_we  output  1  screen RAM write strobe, one cycle per write
- ram_addr  output  ADDR_W  write address, row*COLS + col
- ram_data  output  8  write data
- cursor_col  output  7  current column, 0..COLS-1
- cursor_row  output  5  current row, 0..ROWS-1
- busy  output  1  clear sequence in progress

## Operation
- States: CLEAR and IDLE.
- While reset is low: state is CLEAR and the clear counter is 0. All outputs are 0: in_ready, ram_we, ram_addr, ram_data, cursor_col and cursor_row. busy is 1.
- CLEAR:
  - Writes BLANK to addresses 0..COLS*ROWS-1, one address per cycle, in ascending order.
  - busy=1 and in_ready=0 throughout.
  - After address COLS*ROWS-1 is written, the cursor is set to (0,0), busy goes to 0 and the state moves to IDLE.
- IDLE: in_ready=1. A byte is accepted in any cycle where in_valid and in_ready are both 1.
- Printable byte (0x20..0x7E):
  - Written at the cursor position.
  - Then col increments.
  - At col=COLS-1 the cursor wraps: col=0 and row+1.
  - At row=ROWS-1 the row wraps to 0. There is no scrolling.
- 0x0A (LF): col=0 and row+1, with the same row wrap. No write.
- 0x0D (CR): col=0. No write.
- 0x08 (BS):
  - If col>0: col-1, then BLANK is written at the new position.
  - If col=0: no operation. The cursor never retreats to the previous row.
- 0x0C (FF): enter CLEAR. in_ready drops in the following cycle, and the cursor becomes (0,0) when the clear completes.
- All other bytes (0x00..0x1F not listed above, and 0x7F..0xFF): accepted and discarded. No write and no cursor change.
- Address arithmetic:
  - Computed as row*COLS + col in ADDR_W bits.
  - For COLS=80 this is implemented as (row<<6)+(row<<4)+col, with no multiplier.
  - The result never exceeds COLS*ROWS-1.

## Timing
- ram_we, ram_addr and ram_data are registered. A write triggered by an acceptance in cycle N is presented in cycle N+1, for exactly one cycle.
- The cursor outputs update in cycle N+1.
- ram_addr in cycle N+1 is the pre-advance position for a printable byte and the post-decrement position for BS.
- Throughput is one byte per cycle in IDLE, and back-to-back printables produce consecutive writes.
- in_ready is a registered function of state only and never depends on in_valid.
- When FF is accepted in cycle N, in_ready=0 and busy=1 from cycle N+1. The first BLANK write (address 0) also appears in cycle N+1.
- A clear occupies exactly COLS*ROWS cycles of ram_we=1. in_ready returns to 1 in the cycle after the last clear write.
- While ram_we=0, ram_addr and ram_data hold their last values.
- If reset asserts mid-clear or mid-write, everything returns to the reset values immediately. The full clear restarts from address 0 after release.

## Structure
- Shared package vga_text_pkg holds:
  - the COLS and ROWS defaults;
  - the control-code constants (ASCII_LF, ASCII_CR, ASCII_BS, ASCII_FF, ASCII_SP);
  - the state enum with CLEAR and IDLE.
- One sub-module, text_cursor, is natural. It holds the col/row registers with set-home, advance, newline, CR and decrement operations and the wrap logic. It outputs row*COLS+col.
- The text_writer top contains the FSM, the clear counter and the output registers.

## Test plan
- Reset, then release -> 2400 consecutive writes of 0x20 at addresses 0..2399. Then busy=0, in_ready=1 and the cursor is (0,0).
- Send "AB" back-to-back -> writes (0,0x41) and (1,0x42) in consecutive cycles. Cursor ends at col 2.
- Send 80 printables from col 0 on row 29 -> the last write is at address 2399 and the cursor wraps to (0,0).
- Send "X", BS, BS -> write 0x58@0, then 0x20@0, then no write. Cursor stays at col 0.
- Cursor at (5,3), send LF then CR -> cursor (0,4) with no ram_we. Then send 0x01 -> it is accepted with no effect.
- Send FF mid-stream, and assert reset halfway through the clear -> outputs are 0 immediately. After release the clear restarts at address 0 and completes 2400 writes.
